minmax_tracker_4bit: RTL and testbench

MINMAX_TRACKER_4BIT -- requirements
Module: minmax_tracker_4bit

---
 rtl/minmax_pkg.sv | 20 ++
 rtl/mag_cmp4.sv | 16 +
 rtl/minmax_tracker_4bit.sv | 136 +++++++++++++
 tb/tb_minmax_tracker_4bit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared types and widths for the 4-bit min/max window tracker.
// Holds the FSM state encoding and the magnitude-compare result bundle.
package minmax_pkg;

  localparam int DATA_W  = 4;
  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_t;

endpackage

// File: rtl/mag_cmp4.sv
// Unsigned 4-bit magnitude comparator: reports a == b, a > b and a < b.
module mag_cmp4
  import minmax_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output cmp_t              cmp_o
);

  always_comb begin
    cmp_o.eq = (a_i == b_i);
    cmp_o.gt = (a_i > b_i);
    cmp_o.lt = (a_i < b_i);
  end

endmodule

// File: rtl/minmax_tracker_4bit.sv
// Tracks min/max/count over windows of WIN_LEN samples with valid/ready handshakes.
// Optional out_range (max - min) output is enabled by defining MINMAX_TRACKER_RANGE_EN.
module minmax_tracker_4bit
  import minmax_pkg::*;
#(
  parameter int unsigned WIN_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_min,
  output logic [DATA_W-1:0]  out_max,
  output logic [COUNT_W-1:0] out_count
`ifdef MINMAX_TRACKER_RANGE_EN
  ,
  output logic [DATA_W-1:0]  out_range
`endif
);

  localparam logic [COUNT_W-1:0] WIN_LEN_C = COUNT_W'(WIN_LEN);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  min_q, min_d;
  logic [DATA_W-1:0]  max_q, max_d;
  logic [COUNT_W-1:0] count_q, count_d;

  cmp_t cmpMin;
  cmp_t cmpMax;
  logic accept;
  logic minUpdate;
  logic maxUpdate;

  mag_cmp4 u_cmp_min (
    .a_i   (in_data),
    .b_i   (min_q),
    .cmp_o (cmpMin)
  );

  mag_cmp4 u_cmp_max (
    .a_i   (in_data),
    .b_i   (max_q),
    .cmp_o (cmpMax)
  );

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  // Equal samples must leave the extremes untouched, so only a strict result updates.
  assign minUpdate = cmpMin.lt && !(cmpMin.eq || cmpMin.gt);
  assign maxUpdate = cmpMax.gt && !(cmpMax.eq || cmpMax.lt);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    count_d = count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          min_d   = in_data;
          max_d   = in_data;
          count_d = COUNT_W'(1);
          state_d = (WIN_LEN_C == COUNT_W'(1)) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (minUpdate) min_d = in_data;
          if (maxUpdate) max_d = in_data;
          count_d = count_q + COUNT_W'(1);
          if (count_d == WIN_LEN_C) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over both the input and output handshakes.
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      min_d   = '1;
      max_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= '1;
      max_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      count_q <= count_d;
    end
  end

  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = count_q;

`ifdef MINMAX_TRACKER_RANGE_EN
  logic [DATA_W-1:0] range_q, range_d;

  // Range is only meaningful alongside a finished window; zero otherwise.
  always_comb begin
    range_d = '0;
    if (state_d == DONE) range_d = max_d - min_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) range_q <= '0;
    else     range_q <= range_d;
  end

  assign out_range = range_q;
`endif

endmodule

// File: tb/tb_minmax_tracker_4bit.sv
// Directed testbench for minmax_tracker_4bit (WIN_LEN=8 and WIN_LEN=1 instances).
// Define MINMAX_TRACKER_RANGE_EN to also exercise the out_range output.
module tb_minmax_tracker_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, clear, out_valid, out_ready;
  logic [3:0] in_data, out_min, out_max;
  logic [7:0] out_count;

  logic       inValidOne, inReadyOne, clearOne, outValidOne, outReadyOne;
  logic [3:0] inDataOne, outMinOne, outMaxOne;
  logic [7:0] outCountOne;

`ifdef MINMAX_TRACKER_RANGE_EN
  logic [3:0] out_range, outRangeOne;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running 10-time-unit clock shared by both instances.
  always #5 clk = ~clk;

  minmax_tracker_4bit #(.WIN_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count)
`ifdef MINMAX_TRACKER_RANGE_EN
    ,
    .out_range (out_range)
`endif
  );

  minmax_tracker_4bit #(.WIN_LEN(1)) dutOne (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValidOne),
    .in_ready  (inReadyOne),
    .in_data   (inDataOne),
    .clear     (clearOne),
    .out_valid (outValidOne),
    .out_ready (outReadyOne),
    .out_min   (outMinOne),
    .out_max   (outMaxOne),
    .out_count (outCountOne)
`ifdef MINMAX_TRACKER_RANGE_EN
    ,
    .out_range (outRangeOne)
`endif
  );

  // Advance one clock and settle just after the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'hF, 4'h0, 8'd0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b0, 4'hF, 4'h0, 8'd0});
    end
    rst = 1'b0;
    step();
    testsRun++;
    if (in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [3:0] s [8];
    s = '{4'd5, 4'd3, 4'd9, 4'd9, 4'd0, 4'd15, 4'd7, 4'd4};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      step();
      if (i == 2) begin
        testsRun++;
        if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'd3, 4'd9, 8'd3}) begin
          testsFailed++;
          $display("[TB] FAIL basic_partial: got %h expected %h",
                   {out_valid, out_min, out_max, out_count}, {1'b0, 4'd3, 4'd9, 8'd3});
        end
      end
      if (i == 6) begin
        testsRun++;
        if (out_valid !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL basic_early_valid: got %b expected 0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b1, 4'd0, 4'd15, 8'd8}) begin
      testsFailed++;
      $display("[TB] FAIL basic_result: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b1, 4'd0, 4'd15, 8'd8});
    end
    testsRun++;
    if (in_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_done_ready: got %b expected 0", in_ready);
    end
    // Sample offered during the handshake cycle must be ignored.
    in_valid = 1'b1;
    in_data  = 4'd2;
    step();
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_count, in_ready} !== {1'b0, 8'd0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL basic_handshake: got %h expected %h",
               {out_valid, out_count, in_ready}, {1'b0, 8'd0, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      step();
    end
    in_data = 4'd12;
    for (int i = 0; i < 5; i++) begin
      step();
      testsRun++;
      if ({in_ready, out_valid, out_min, out_max, out_count} !== {1'b0, 1'b1, 4'd1, 4'd8, 8'd8}) begin
        testsFailed++;
        $display("[TB] FAIL stall_hold cycle %0d: got %h expected %h", i,
                 {in_ready, out_valid, out_min, out_max, out_count},
                 {1'b0, 1'b1, 4'd1, 4'd8, 8'd8});
      end
    end
    out_ready = 1'b1;
    step();
    testsRun++;
    if ({out_valid, out_count, in_ready} !== {1'b0, 8'd0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL stall_release: got %h expected %h",
               {out_valid, out_count, in_ready}, {1'b0, 8'd0, 1'b1});
    end
    step();
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'd12, 4'd12, 8'd1}) begin
      testsFailed++;
      $display("[TB] FAIL stall_first_new: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b0, 4'd12, 4'd12, 8'd1});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'hF, 4'h0, 8'd0}) begin
      testsFailed++;
      $display("[TB] FAIL clear_accum: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b0, 4'hF, 4'h0, 8'd0});
    end
  endtask

  task automatic test_equal();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 4'd4;
      step();
    end
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b1, 4'd4, 4'd4, 8'd8}) begin
      testsFailed++;
      $display("[TB] FAIL equal_window: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b1, 4'd4, 4'd4, 8'd8});
    end
    step();
  endtask

  task automatic test_clear();
    logic [3:0] s [8];
    s = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd13, 4'd12, 4'd11};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data = 4'd6; step();
    in_data = 4'd2; step();
    in_data = 4'd8; step();
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'd2, 4'd8, 8'd3}) begin
      testsFailed++;
      $display("[TB] FAIL clear_pre: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b0, 4'd2, 4'd8, 8'd3});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'hF, 4'h0, 8'd0}) begin
      testsFailed++;
      $display("[TB] FAIL clear_pulse: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b0, 4'hF, 4'h0, 8'd0});
    end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      step();
    end
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b1, 4'd10, 4'd14, 8'd8}) begin
      testsFailed++;
      $display("[TB] FAIL clear_fresh: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b1, 4'd10, 4'd14, 8'd8});
    end
    // Clear in DONE overrides a simultaneous handshake and offered sample.
    out_ready = 1'b1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'd3;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'hF, 4'h0, 8'd0}) begin
      testsFailed++;
      $display("[TB] FAIL clear_done: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b0, 4'hF, 4'h0, 8'd0});
    end
  endtask

  task automatic test_win1();
    outReadyOne = 1'b0;
    inValidOne  = 1'b1;
    inDataOne   = 4'd11;
    step();
    inValidOne = 1'b0;
    testsRun++;
    if ({outValidOne, inReadyOne, outMinOne, outMaxOne, outCountOne} !==
        {1'b1, 1'b0, 4'd11, 4'd11, 8'd1}) begin
      testsFailed++;
      $display("[TB] FAIL win1_result: got %h expected %h",
               {outValidOne, inReadyOne, outMinOne, outMaxOne, outCountOne},
               {1'b1, 1'b0, 4'd11, 4'd11, 8'd1});
    end
    outReadyOne = 1'b1;
    step();
    testsRun++;
    if ({outValidOne, outCountOne} !== {1'b0, 8'd0}) begin
      testsFailed++;
      $display("[TB] FAIL win1_handshake: got %h expected %h",
               {outValidOne, outCountOne}, {1'b0, 8'd0});
    end
  endtask

`ifdef MINMAX_TRACKER_RANGE_EN
  task automatic test_range();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 2);
      step();
    end
    in_valid = 1'b0;
    testsRun++;
    if ({out_valid, out_range} !== {1'b1, 4'd7}) begin
      testsFailed++;
      $display("[TB] FAIL range_value: got %h expected %h", {out_valid, out_range}, {1'b1, 4'd7});
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    testsRun++;
    if (out_range !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL range_clear: got %h expected 0", out_range);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic sawValid;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      step();
    end
    in_valid = 1'b0;
    testsRun++;
    if (out_count !== 8'd5) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_pre: got %0d expected 5", out_count);
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if ({out_valid, out_min, out_max, out_count} !== {1'b0, 4'hF, 4'h0, 8'd0}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_async: got %h expected %h",
               {out_valid, out_min, out_max, out_count}, {1'b0, 4'hF, 4'h0, 8'd0});
    end
    step();
    rst = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid !== 1'b0) sawValid = 1'b1;
    end
    testsRun++;
    if ({sawValid, out_count, in_ready} !== {1'b0, 8'd0, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_no_result: got %h expected %h",
               {sawValid, out_count, in_ready}, {1'b0, 8'd0, 1'b1});
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 4'd0;
    clear       = 1'b0;
    out_ready   = 1'b0;
    inValidOne  = 1'b0;
    inDataOne   = 4'd0;
    clearOne    = 1'b0;
    outReadyOne = 1'b0;

    test_reset();
    test_basic();
    test_back_to_back();
    test_equal();
    test_clear();
    test_win1();
`ifdef MINMAX_TRACKER_RANGE_EN
    test_range();
`endif
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
